// File: rtl/inverse_kronecker_pkg.sv
// inverse_kronecker_pkg
// Shared constants, widths and helpers for the 8-point inverse transform.
// Holds the 7 distinct coefficient magnitudes, the datapath widths,
// the rounding/shift/saturation constants and the small arithmetic
// helpers used by both the top level and the odd-part sub-module.
package inverse_kronecker_pkg;

    localparam int IN_W   = 12;
    localparam int OUT_W  = 8;
    localparam int PROD_W = 20;
    localparam int ACC_W  = 22;

    localparam logic signed [PROD_W-1:0] C64 = 20'sd64;
    localparam logic signed [PROD_W-1:0] C89 = 20'sd89;
    localparam logic signed [PROD_W-1:0] C83 = 20'sd83;
    localparam logic signed [PROD_W-1:0] C75 = 20'sd75;
    localparam logic signed [PROD_W-1:0] C50 = 20'sd50;
    localparam logic signed [PROD_W-1:0] C36 = 20'sd36;
    localparam logic signed [PROD_W-1:0] C18 = 20'sd18;

    localparam logic signed [ACC_W-1:0] ROUND   = 22'sd256;
    localparam int                      SHIFT   = 9;
    localparam logic signed [ACC_W-1:0] SAT_MAX = 22'sd127;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -22'sd128;

    typedef struct packed {
        logic signed [OUT_W-1:0] val;
        logic                    clip;
    } sat_t;

    // Coefficient magnitudes are all positive; signs are applied in the sums.
    function automatic logic signed [PROD_W-1:0] mul_c(
        input logic signed [IN_W-1:0]   x,
        input logic signed [PROD_W-1:0] c
    );
        logic signed [PROD_W-1:0] xe;
        xe = {{(PROD_W-IN_W){x[IN_W-1]}}, x};
        return xe * c;
    endfunction

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Floor shift (arithmetic) after adding half an LSB, then clip to 8 bits.
    function automatic sat_t round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        sat_t                    res;
        r = (acc + ROUND) >>> SHIFT;
        if (r > SAT_MAX) begin
            res.val  = SAT_MAX[OUT_W-1:0];
            res.clip = 1'b1;
        end else if (r < SAT_MIN) begin
            res.val  = SAT_MIN[OUT_W-1:0];
            res.clip = 1'b1;
        end else begin
            res.val  = r[OUT_W-1:0];
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/idct_odd_part.sv
// idct_odd_part
// Odd half of the inverse transform: O[0..3] from X1/X3/X5/X7.
// Stage 1 registers the 16 products, stage 2 registers the four sums.
// Ports: i_clk, i_rst (async, active high), i_en (advance enable),
//        i_x1/i_x3/i_x5/i_x7 (12-bit signed), o_odd0..3 (22-bit signed).
module idct_odd_part
    import inverse_kronecker_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic signed [IN_W-1:0]  i_x1,
    input  logic signed [IN_W-1:0]  i_x3,
    input  logic signed [IN_W-1:0]  i_x5,
    input  logic signed [IN_W-1:0]  i_x7,
    output logic signed [ACC_W-1:0] o_odd0,
    output logic signed [ACC_W-1:0] o_odd1,
    output logic signed [ACC_W-1:0] o_odd2,
    output logic signed [ACC_W-1:0] o_odd3
);

    // p<k>[n] holds |M[k][n]| * X<k>
    logic signed [PROD_W-1:0] p1 [4];
    logic signed [PROD_W-1:0] p3 [4];
    logic signed [PROD_W-1:0] p5 [4];
    logic signed [PROD_W-1:0] p7 [4];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                p1[i] <= '0;
                p3[i] <= '0;
                p5[i] <= '0;
                p7[i] <= '0;
            end
        end else if (i_en) begin
            p1[0] <= mul_c(i_x1, C89); p1[1] <= mul_c(i_x1, C75);
            p1[2] <= mul_c(i_x1, C50); p1[3] <= mul_c(i_x1, C18);
            p3[0] <= mul_c(i_x3, C75); p3[1] <= mul_c(i_x3, C18);
            p3[2] <= mul_c(i_x3, C89); p3[3] <= mul_c(i_x3, C50);
            p5[0] <= mul_c(i_x5, C50); p5[1] <= mul_c(i_x5, C89);
            p5[2] <= mul_c(i_x5, C18); p5[3] <= mul_c(i_x5, C75);
            p7[0] <= mul_c(i_x7, C18); p7[1] <= mul_c(i_x7, C50);
            p7[2] <= mul_c(i_x7, C75); p7[3] <= mul_c(i_x7, C89);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_odd0 <= '0;
            o_odd1 <= '0;
            o_odd2 <= '0;
            o_odd3 <= '0;
        end else if (i_en) begin
            o_odd0 <= ext(p1[0]) + ext(p3[0]) + ext(p5[0]) + ext(p7[0]);
            o_odd1 <= ext(p1[1]) - ext(p3[1]) - ext(p5[1]) - ext(p7[1]);
            o_odd2 <= ext(p1[2]) - ext(p3[2]) + ext(p5[2]) + ext(p7[2]);
            o_odd3 <= ext(p1[3]) - ext(p3[3]) + ext(p5[3]) - ext(p7[3]);
        end
    end

endmodule

// File: rtl/inverse_kronecker.sv
// inverse_kronecker
// 8-point inverse transform of one coefficient row per cycle, 3-stage
// pipeline with a single global advance enable (en = !o_valid || i_ready).
// Ports: i_clk, i_rst (async, active high); i_valid/o_ready/i_data0..7
//        input row handshake (12-bit signed coefficients); o_valid/i_ready/
//        o_data0..7 output row handshake (8-bit signed samples); o_last marks
//        the 8th row of a block; o_sat flags a clipped sample in the row.
module inverse_kronecker
    import inverse_kronecker_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [IN_W-1:0]  i_data0,
    input  logic signed [IN_W-1:0]  i_data1,
    input  logic signed [IN_W-1:0]  i_data2,
    input  logic signed [IN_W-1:0]  i_data3,
    input  logic signed [IN_W-1:0]  i_data4,
    input  logic signed [IN_W-1:0]  i_data5,
    input  logic signed [IN_W-1:0]  i_data6,
    input  logic signed [IN_W-1:0]  i_data7,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [OUT_W-1:0] o_data0,
    output logic signed [OUT_W-1:0] o_data1,
    output logic signed [OUT_W-1:0] o_data2,
    output logic signed [OUT_W-1:0] o_data3,
    output logic signed [OUT_W-1:0] o_data4,
    output logic signed [OUT_W-1:0] o_data5,
    output logic signed [OUT_W-1:0] o_data6,
    output logic signed [OUT_W-1:0] o_data7,
    output logic                    o_last,
    output logic                    o_sat
);

    logic                     en;
    logic                     v1, v2;
    logic signed [PROD_W-1:0] pe0, pe4, pe2a, pe2b, pe6a, pe6b;
    logic signed [ACC_W-1:0]  ev  [4];
    logic signed [ACC_W-1:0]  od  [4];
    logic signed [ACC_W-1:0]  sum [8];
    sat_t                     rs  [8];
    logic                     clip_any;
    logic signed [OUT_W-1:0]  y_q [8];
    logic [2:0]               row_cnt;

    assign en      = !o_valid || i_ready;
    assign o_ready = en;
    assign o_last  = o_valid && (row_cnt == 3'd7);

    // S1: even products (odd products live in the sub-module)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1   <= 1'b0;
            pe0  <= '0;
            pe4  <= '0;
            pe2a <= '0;
            pe2b <= '0;
            pe6a <= '0;
            pe6b <= '0;
        end else if (en) begin
            v1   <= i_valid;
            pe0  <= mul_c(i_data0, C64);
            pe4  <= mul_c(i_data4, C64);
            pe2a <= mul_c(i_data2, C83);
            pe2b <= mul_c(i_data2, C36);
            pe6a <= mul_c(i_data6, C83);
            pe6b <= mul_c(i_data6, C36);
        end
    end

    // S2: even sums
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v2 <= 1'b0;
            for (int i = 0; i < 4; i++) ev[i] <= '0;
        end else if (en) begin
            v2    <= v1;
            ev[0] <= ext(pe0) + ext(pe2a) + ext(pe4) + ext(pe6b);
            ev[1] <= ext(pe0) + ext(pe2b) - ext(pe4) - ext(pe6a);
            ev[2] <= ext(pe0) - ext(pe2b) - ext(pe4) + ext(pe6a);
            ev[3] <= ext(pe0) - ext(pe2a) + ext(pe4) - ext(pe6b);
        end
    end

    idct_odd_part u_odd (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (en),
        .i_x1   (i_data1),
        .i_x3   (i_data3),
        .i_x5   (i_data5),
        .i_x7   (i_data7),
        .o_odd0 (od[0]),
        .o_odd1 (od[1]),
        .o_odd2 (od[2]),
        .o_odd3 (od[3])
    );

    // Butterfly: x[n] = E[n] + O[n], x[7-n] = E[n] - O[n]
    always_comb begin
        clip_any = 1'b0;
        for (int n = 0; n < 8; n++) begin
            sum[n] = '0;
            rs[n]  = '0;
        end
        for (int n = 0; n < 4; n++) begin
            sum[n]     = ev[n] + od[n];
            sum[7 - n] = ev[n] - od[n];
        end
        for (int n = 0; n < 8; n++) begin
            rs[n]    = round_sat(sum[n]);
            clip_any = clip_any | rs[n].clip;
        end
    end

    // S3: output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
            for (int n = 0; n < 8; n++) y_q[n] <= '0;
        end else if (en) begin
            o_valid <= v2;
            o_sat   <= clip_any;
            for (int n = 0; n < 8; n++) y_q[n] <= rs[n].val;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_cnt <= 3'd0;
        end else if (o_valid && i_ready) begin
            row_cnt <= row_cnt + 3'd1;
        end
    end

    assign o_data0 = y_q[0];
    assign o_data1 = y_q[1];
    assign o_data2 = y_q[2];
    assign o_data3 = y_q[3];
    assign o_data4 = y_q[4];
    assign o_data5 = y_q[5];
    assign o_data6 = y_q[6];
    assign o_data7 = y_q[7];

endmodule

// File: tb/tb_inverse_kronecker.sv
// tb_inverse_kronecker
// Self-checking bench: directed rows for the known-answer cases, then
// randomized rows and handshakes against a full-matrix reference model.
module tb_inverse_kronecker;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_valid;
    logic              i_ready;
    logic              o_ready;
    logic              o_valid;
    logic              o_last;
    logic              o_sat;
    logic signed [11:0] din  [8];
    logic signed [7:0]  dout [8];

    always #5 i_clk = ~i_clk;

    inverse_kronecker dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data0 (din[0]), .i_data1 (din[1]), .i_data2 (din[2]), .i_data3 (din[3]),
        .i_data4 (din[4]), .i_data5 (din[5]), .i_data6 (din[6]), .i_data7 (din[7]),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data0 (dout[0]), .o_data1 (dout[1]), .o_data2 (dout[2]), .o_data3 (dout[3]),
        .o_data4 (dout[4]), .o_data5 (dout[5]), .o_data6 (dout[6]), .o_data7 (dout[7]),
        .o_last  (o_last),
        .o_sat   (o_sat)
    );

    localparam int M [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    typedef struct {
        int d[8];
        bit sat;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   out_cnt  = 0;
    int   n_out    = 0;
    int   last_seen = 0;
    int   last_d[8];
    int   last_sat = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t model(input int x[8]);
        exp_t e;
        e.sat = 1'b0;
        for (int n = 0; n < 8; n++) begin
            int s;
            int y;
            s = 0;
            for (int k = 0; k < 8; k++) s += M[k][n] * x[k];
            y = (s + 256) >>> 9;
            if (y > 127) begin y = 127; e.sat = 1'b1; end
            if (y < -128) begin y = -128; e.sat = 1'b1; end
            e.d[n] = y;
        end
        return e;
    endfunction

    function automatic logic signed [11:0] rnd_x();
        if ($urandom_range(0, 1) == 1) return 12'($urandom_range(0, 4095));
        return 12'(int'($urandom_range(0, 255)) - 128);
    endfunction

    // One clock: observe handshakes at the falling edge, then advance.
    task automatic cycle();
        int   x[8];
        exp_t e;
        @(negedge i_clk);
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_row", 1, 0);
            end else begin
                e = sb.pop_front();
                for (int n = 0; n < 8; n++) begin
                    chk($sformatf("x%0d", n), int'(dout[n]), e.d[n]);
                    last_d[n] = int'(dout[n]);
                end
                chk("sat", int'(o_sat), int'(e.sat));
                chk("last", int'(o_last), int'(out_cnt == 7));
                last_sat = int'(o_sat);
                if (o_last) last_seen++;
                out_cnt = (out_cnt + 1) % 8;
                n_out++;
            end
        end
        if (i_valid && o_ready) begin
            for (int k = 0; k < 8; k++) x[k] = int'(din[k]);
            sb.push_back(model(x));
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while (sb.size() > 0 && guard < 100) begin
            cycle();
            guard++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic send_one(input int k, input int v);
        for (int i = 0; i < 8; i++) din[i] = '0;
        din[k]  = 12'(v);
        i_valid = 1'b1;
        i_ready = 1'b1;
        cycle();
        drain();
    endtask

    task automatic rand_row();
        for (int i = 0; i < 8; i++) din[i] = rnd_x();
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1 chk("rst_async_valid", int'(o_valid), 0);
        chk("rst_async_last", int'(o_last), 0);
        sb.delete();
        out_cnt = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("ready_after_rst", int'(o_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int held[8];
        int held_sat;
        int guard;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) din[i] = '0;
        #2;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_sat", int'(o_sat), 0);
        chk("rst_o_last", int'(o_last), 0);
        for (int n = 0; n < 8; n++) chk($sformatf("rst_x%0d", n), int'(dout[n]), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("ready_first_cycle", int'(o_ready), 1);

        // all-zero row: latency 3
        i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            cycle();
            lat++;
        end
        chk("latency", lat, 3);
        drain();
        chk("zero_x0", last_d[0], 0);
        chk("zero_sat", last_sat, 0);

        send_one(0, 512);
        chk("dc512_x0", last_d[0], 64);
        chk("dc512_x7", last_d[7], 64);
        send_one(0, 1016);
        chk("dc1016_x3", last_d[3], 127);
        chk("dc1016_sat", last_sat, 0);
        send_one(1, 512);
        chk("ac1_x0", last_d[0], 89);
        chk("ac1_x7", last_d[7], -89);
        send_one(0, 2047);
        chk("dcmax_x4", last_d[4], 127);
        chk("dcmax_sat", last_sat, 1);
        send_one(0, -2048);
        chk("dcmin_x2", last_d[2], -128);
        chk("dcmin_sat", last_sat, 1);

        // 16 back-to-back rows from a fresh block
        do_reset();
        last_seen = 0;
        n_out     = 0;
        i_ready   = 1'b1;
        for (int r = 0; r < 16; r++) begin
            rand_row();
            i_valid = 1'b1;
            cycle();
        end
        drain();
        chk("b2b_rows", n_out, 16);
        chk("b2b_lasts", last_seen, 2);

        // stall with 3 rows in flight
        i_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            rand_row();
            i_valid = 1'b1;
            cycle();
        end
        chk("stall_valid", int'(o_valid), 1);
        chk("stall_ready", int'(o_ready), 0);
        for (int n = 0; n < 8; n++) held[n] = int'(dout[n]);
        held_sat = int'(o_sat);
        for (int c = 0; c < 5; c++) begin
            rand_row();
            cycle();
            chk("stall_ready_hold", int'(o_ready), 0);
            chk("stall_valid_hold", int'(o_valid), 1);
            chk("stall_sat_hold", int'(o_sat), held_sat);
            for (int n = 0; n < 8; n++) chk($sformatf("stall_x%0d_hold", n), int'(dout[n]), held[n]);
        end
        n_out = 0;
        drain();
        chk("stall_rows_out", n_out, 3);

        // reset in the middle of a block
        do_reset();
        i_ready = 1'b1;
        guard   = 0;
        while (out_cnt != 4 && guard < 50) begin
            rand_row();
            i_valid = 1'b1;
            cycle();
            guard++;
        end
        chk("mid_block_cnt", out_cnt, 4);
        chk("mid_block_valid", int'(o_valid), 1);
        do_reset();
        last_seen = 0;
        n_out     = 0;
        for (int r = 0; r < 8; r++) begin
            rand_row();
            i_valid = 1'b1;
            cycle();
        end
        drain();
        chk("post_rst_rows", n_out, 8);
        chk("post_rst_lasts", last_seen, 1);

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            rand_row();
            i_valid = 1'($urandom_range(0, 1));
            i_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inverse_kronecker.md
INVERSE_KRONECKER -- requirements
Module: inverse_kronecker

Interface
REQ-001 SHALL have ports: i_clk, input, 1, sole clock, all state changes on its rising edge.
REQ-002 SHALL have ports: i_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports: i_valid, input, 1, a coefficient row is presented.
REQ-004 SHALL have ports: o_ready, output, 1, the block accepts a row this cycle.
REQ-005 SHALL have ports: i_data0..i_data7, input, 12 each, signed frequency coefficients X[0..7].
REQ-006 SHALL have ports: o_valid, output, 1, a reconstructed sample row is present.
REQ-007 SHALL have ports: i_ready, input, 1, downstream accepts the output row.
REQ-008 SHALL have ports: o_data0..o_data7, output, 8 each, signed reconstructed samples x[0..7].
REQ-009 SHALL have ports: o_last, output, 1, qualifies the 8th output row of an 8x8 block.
REQ-010 SHALL have ports: o_sat, output, 1, at least one sample in the current output row was clipped.

Function
REQ-011 SHALL compute x[n] = (sum over k of M[k][n]*X[k] + 256) >>> 9, using an arithmetic (floor) shift.
REQ-012 SHALL use the following rows of M (k=0..7, n=0..7):
- k0: 64 64 64 64 64 64 64 64
- k1: 89 75 50 18 -18 -50 -75 -89
- k2: 83 36 -36 -83 -83 -36 36 83
- k3: 75 -18 -89 -50 50 89 18 -75
- k4: 64 -64 -64 64 64 -64 -64 64
- k5: 50 -89 18 75 -75 -18 89 -50
- k6: 36 -83 83 -36 -36 83 -83 36
- k7: 18 -50 75 -89 89 -75 50 -18
REQ-013 SHALL decompose the computation into even and odd parts:
- even part from X0, X2, X4, X6; odd part from X1, X3, X5, X7;
- x[n] = E[n] + O[n] and x[7-n] = E[n] - O[n], for n = 0..3.
REQ-014 SHALL size the datapath as follows:
- products 20-bit signed;
- all accumulations 22-bit signed;
- no intermediate truncation before the final shift.
REQ-015 SHALL saturate each shifted result to the range [-128, 127]; o_sat is the OR of all eight clip events of the row.
REQ-016 SHALL be a 3-stage pipeline:
- S1: register products;
- S2: register E[0..3] and O[0..3];
- S3: register the butterfly, round, shift and saturate into the output registers.
REQ-017 SHALL have a latency of exactly 3 cycles from input handshake to o_valid when i_ready is held high, with throughput of one row per cycle.
REQ-018 SHALL generate a single global advance enable, en = !o_valid || i_ready; o_ready = en.
REQ-019 SHALL accept an input row only on i_valid && o_ready.
REQ-020 SHALL freeze all stage registers and valid bits while en = 0, so that no row is lost or duplicated.
REQ-021 SHALL hold o_data, o_valid, o_last and o_sat stable while o_valid && !i_ready.
REQ-022 SHALL maintain a 3-bit output row counter:
- increments on o_valid && i_ready;
- wraps 7 -> 0;
- o_last = o_valid && (counter == 7).
REQ-023 SHALL treat an i_valid deasserted for a cycle as a pipeline bubble: no output is produced for it and the counter is not incremented.

Reset
REQ-024 SHALL, on i_rst high and regardless of clock, clear:
- all stage valid bits, o_valid, o_last, o_sat;
- the row counter;
- o_data0..7 to 0.
REQ-025 SHALL drop any rows in flight when reset is asserted mid-operation; the first row accepted after reset deasserts starts a new block at counter 0.
REQ-026 SHALL drive o_ready high on the first cycle after reset deassertion.

Structure
REQ-027 SHALL place in a shared package:
- the coefficient constants 64/89/83/75/50/36/18;
- the widths (12 in, 8 out, 20 product, 22 accumulator);
- ROUND = 256, SHIFT = 9, SAT_MAX = 127, SAT_MIN = -128.
REQ-028 SHALL instantiate one sub-module, idct_odd_part, which computes O[0..3] from X1/X3/X5/X7 with a 2-stage registration that has its own enable; the even part and butterfly stay in the top level.

Verification
REQ-029 SHALL cover this scenario: all-zero row, i_ready=1 -> o_valid 3 cycles later, all outputs 0, o_sat=0.
REQ-030 SHALL cover this scenario: X0=512, others 0 -> all x = 64; X0=1016 -> all x = 127, o_sat=0.
REQ-031 SHALL cover this scenario: X1=512, others 0 -> x0 = 89 and x7 = -89 (floor rounding); X0=2047 -> all 127 with o_sat=1; X0=-2048 -> all -128 with o_sat=1.
REQ-032 SHALL cover this scenario: 16 back-to-back rows with i_ready=1 -> 16 consecutive outputs, o_last high on the 8th and 16th only.
REQ-033 SHALL cover this scenario: with 3 rows in flight, hold i_ready=0 for 5 cycles -> o_ready=0, outputs frozen; release -> the 3 rows emerge in order with no loss or duplication.
REQ-034 SHALL cover this scenario: assert i_rst asynchronously mid-block (counter=4) -> o_valid falls immediately; the next 8 rows produce o_last on the 8th.
